// File: rtl/uart_rx_fifo_pkg.sv
// uart_pkg: shared definitions for the UART receive path and its FIFO.
// Holds the receiver FSM state type, frame geometry constants and the
// helper that widens a received byte into a 16-bit Hack word.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned MID_TICK   = 7;

    // Zero-extend a received byte into a Hack word.
    function automatic logic [15:0] to_hack_word(input logic [7:0] i_byte);
        return {8'h00, i_byte};
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// The head entry is visible on o_RDATA whenever the FIFO is non-empty.
// A write into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is dropped and the contents stay unchanged.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET,
    input  logic                     i_WR,
    input  logic [WIDTH-1:0]         i_WDATA,
    input  logic                     i_RD,
    output logic [WIDTH-1:0]         o_RDATA,
    output logic                     o_FULL,
    output logic                     o_EMPTY,
    output logic [$clog2(DEPTH):0]   o_COUNT
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign w_do_rd = i_RD && (r_count != '0);
    assign w_do_wr = i_WR && ((r_count != FULL_COUNT) || w_do_rd);

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + 1'b1;
            if (w_do_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge i_CLK) begin
        if (w_do_wr) r_mem[r_wptr] <= i_WDATA;
    end

    assign o_RDATA = r_mem[r_rptr];
    assign o_FULL  = (r_count == FULL_COUNT);
    assign o_EMPTY = (r_count == '0);
    assign o_COUNT = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver, 16x oversampling, feeding a FWFT FIFO
// that presents bytes as zero-extended 16-bit Hack words.
// Optional build macro UART_RX_MAJORITY_EN: each sample point becomes the
// 2-of-3 majority of three consecutive ticks, decided one tick later.
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_TICK = 325,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_Serial_RX,
    input  logic        i_RD,
    output logic [15:0] o_DATA,
    output logic        o_VALID,
    output logic        o_FRAME_ERR,
    output logic        o_OVERRUN,
    input  logic        i_CLR_ERR
);

    localparam int unsigned    TW        = $clog2(CLKS_PER_TICK);
    localparam int unsigned    AW        = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0]  TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [3:0]     SUB_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0]     START_SUB = 4'(MID_TICK + 1);
`else
    localparam logic [3:0]     START_SUB = 4'(MID_TICK);
`endif

    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;
    logic [TW-1:0]   r_tick_cnt;
    logic            w_tick;
    rx_state_t       r_state;
    logic [3:0]      r_sub;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_push;
    logic [7:0]      r_push_byte;
    logic            r_frame_err;
    logic            r_overrun;
    logic [3:0]      w_decide_sub;
    logic            w_decide;
    logic            w_sample;
    logic [7:0]      w_head;
    logic            w_full;
    logic            w_empty;
    logic [AW:0]     w_count;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser on the asynchronous serial line.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_Serial_RX;
            r_sync2 <= r_sync1;
        end
    end

    // Tick prescaler, realigned to the falling edge that opens a frame.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_tick_cnt <= '0;
        end else if ((r_state == IDLE) && !w_rx_s) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick       = (r_tick_cnt == TICK_LAST);
    assign w_decide_sub = (r_state == START) ? START_SUB : SUB_LAST;
    assign w_decide     = w_tick && (r_sub == w_decide_sub);

`ifdef UART_RX_MAJORITY_EN
    logic r_s_a;
    logic r_s_b;

    // Capture the two ticks preceding each decision tick for the vote.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_s_a <= 1'b1;
            r_s_b <= 1'b1;
        end else if (w_tick) begin
            if (r_sub == (w_decide_sub - 4'd2)) r_s_a <= w_rx_s;
            if (r_sub == (w_decide_sub - 4'd1)) r_s_b <= w_rx_s;
        end
    end

    assign w_sample = (r_s_a & r_s_b) | (r_s_a & w_rx_s) | (r_s_b & w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    // Receiver FSM: frame timing, bit assembly, push request and frame error.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state     <= IDLE;
            r_sub       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_byte <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push <= 1'b0;
            // Clear first so a same-cycle error below overrides it.
            if (i_CLR_ERR) r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_sub   <= '0;
                    end
                end
                START: begin
                    if (w_decide) begin
                        r_sub <= '0;
                        if (w_sample) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end else if (w_tick) begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                DATA: begin
                    if (w_decide) begin
                        r_sub              <= '0;
                        r_shift[r_bit_idx] <= w_sample;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else if (w_tick) begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                STOP: begin
                    if (w_decide) begin
                        r_sub   <= '0;
                        r_state <= IDLE;
                        if (w_sample) begin
                            r_push      <= 1'b1;
                            r_push_byte <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky overrun: a push into a full FIFO with no pop alongside it.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_overrun <= 1'b0;
        end else if (r_push && w_full && !i_RD) begin
            r_overrun <= 1'b1;
        end else if (i_CLR_ERR) begin
            r_overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_CLK   (i_CLK),
        .i_RESET (i_RESET),
        .i_WR    (r_push),
        .i_WDATA (r_push_byte),
        .i_RD    (i_RD),
        .o_RDATA (w_head),
        .o_FULL  (w_full),
        .o_EMPTY (w_empty),
        .o_COUNT (w_count)
    );

    assign o_VALID     = (w_count != '0);
    assign o_DATA      = w_empty ? 16'h0000 : to_hack_word(w_head);
    assign o_FRAME_ERR = r_frame_err;
    assign o_OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo with CLKS_PER_TICK=4 (64 clocks per bit).
module tb_uart_rx_fifo;

    localparam int unsigned CPT      = 4;
    localparam int unsigned BIT_CLKS = 16 * CPT;

    logic        i_CLK;
    logic        i_RESET;
    logic        i_Serial_RX;
    logic        i_RD;
    logic [15:0] o_DATA;
    logic        o_VALID;
    logic        o_FRAME_ERR;
    logic        o_OVERRUN;
    logic        i_CLR_ERR;

    int unsigned n_total;
    int unsigned n_pass;

    uart_rx_fifo #(
        .CLKS_PER_TICK (CPT),
        .FIFO_DEPTH    (8)
    ) dut (
        .i_CLK       (i_CLK),
        .i_RESET     (i_RESET),
        .i_Serial_RX (i_Serial_RX),
        .i_RD        (i_RD),
        .o_DATA      (o_DATA),
        .o_VALID     (o_VALID),
        .o_FRAME_ERR (o_FRAME_ERR),
        .o_OVERRUN   (o_OVERRUN),
        .i_CLR_ERR   (i_CLR_ERR)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    typedef struct {
        logic [7:0]  tx;
        logic        stop;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic send_bit(input logic v);
        i_Serial_RX = v;
        repeat (BIT_CLKS) @(negedge i_CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int unsigned n);
        i_Serial_RX = 1'b1;
        repeat (n) @(negedge i_CLK);
    endtask

    task automatic pop();
        i_RD = 1'b1;
        @(negedge i_CLK);
        i_RD = 1'b0;
        @(negedge i_CLK);
    endtask

    task automatic clr_err();
        i_CLR_ERR = 1'b1;
        @(negedge i_CLK);
        i_CLR_ERR = 1'b0;
        @(negedge i_CLK);
    endtask

    initial begin
        logic [7:0] exp_after[8];
        logic       found;

        n_total     = 0;
        n_pass      = 0;
        i_RESET     = 1'b1;
        i_Serial_RX = 1'b1;
        i_RD        = 1'b0;
        i_CLR_ERR   = 1'b0;

        vecs[0] = '{tx: 8'h41, stop: 1'b1, exp_valid: 1'b1, exp_data: 16'h0041, exp_ferr: 1'b0};
        vecs[1] = '{tx: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 16'h0000, exp_ferr: 1'b0};
        vecs[2] = '{tx: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 16'h00FF, exp_ferr: 1'b0};
        vecs[3] = '{tx: 8'h55, stop: 1'b0, exp_valid: 1'b0, exp_data: 16'h0000, exp_ferr: 1'b1};
        vecs[4] = '{tx: 8'h5A, stop: 1'b1, exp_valid: 1'b1, exp_data: 16'h005A, exp_ferr: 1'b0};
        vecs[5] = '{tx: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_data: 16'h0080, exp_ferr: 1'b0};

        repeat (4) @(negedge i_CLK);
        i_RESET = 1'b0;
        @(negedge i_CLK);
        check("reset_valid", 16'(o_VALID), 16'h0);
        check("reset_data", o_DATA, 16'h0000);
        check("reset_ferr", 16'(o_FRAME_ERR), 16'h0);
        check("reset_ovr", 16'(o_OVERRUN), 16'h0);
        idle(20);

        // Single-frame vectors
        for (int v = 0; v < 6; v++) begin
            send_byte(vecs[v].tx, vecs[v].stop);
            idle(80);
            check($sformatf("vec%0d_valid", v), 16'(o_VALID), 16'(vecs[v].exp_valid));
            check($sformatf("vec%0d_data", v), o_DATA, vecs[v].exp_data);
            check($sformatf("vec%0d_ferr", v), 16'(o_FRAME_ERR), 16'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_ovr", v), 16'(o_OVERRUN), 16'h0);
            if (vecs[v].exp_ferr) begin
                clr_err();
                check($sformatf("vec%0d_ferr_clr", v), 16'(o_FRAME_ERR), 16'h0);
            end else begin
                pop();
                check($sformatf("vec%0d_valid_after_pop", v), 16'(o_VALID), 16'h0);
            end
        end

        // Pop on empty FIFO is ignored
        pop();
        check("empty_pop_valid", 16'(o_VALID), 16'h0);
        check("empty_pop_data", o_DATA, 16'h0000);

        // Short low glitch on idle line is rejected
        i_Serial_RX = 1'b0;
        repeat (20) @(negedge i_CLK);
        idle(100);
        check("glitch_valid", 16'(o_VALID), 16'h0);
        check("glitch_ferr", 16'(o_FRAME_ERR), 16'h0);
        send_byte(8'h3C, 1'b1);
        idle(40);
        check("post_glitch_data", o_DATA, 16'h003C);
        pop();

        // Back-to-back frames with one stop bit
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h0D, 1'b1);
        idle(40);
        check("b2b_valid", 16'(o_VALID), 16'h1);
        check("b2b_data0", o_DATA, 16'h0041);
        pop();
        check("b2b_data1", o_DATA, 16'h0042);
        pop();
        check("b2b_data2", o_DATA, 16'h000D);
        pop();
        check("b2b_empty_valid", 16'(o_VALID), 16'h0);
        check("b2b_empty_data", o_DATA, 16'h0000);

        // Nine bytes without reading: ninth overruns
        for (int b = 1; b <= 9; b++) send_byte(8'(b), 1'b1);
        idle(40);
        check("ovr_set", 16'(o_OVERRUN), 16'h1);
        check("ovr_head", o_DATA, 16'h0001);
        clr_err();
        check("ovr_clr", 16'(o_OVERRUN), 16'h0);

        // Full FIFO, pop coincides with push of a tenth byte
        found = 1'b0;
        fork
            send_byte(8'h0A, 1'b1);
            begin
                for (int i = 0; i < 1000 && !found; i++) begin
                    @(negedge i_CLK);
                    if (dut.r_push) begin
                        found = 1'b1;
                        i_RD  = 1'b1;
                        @(negedge i_CLK);
                        i_RD  = 1'b0;
                    end
                end
            end
        join
        idle(40);
        check("push_pop_seen", 16'(found), 16'h1);
        check("push_pop_ovr", 16'(o_OVERRUN), 16'h0);
        exp_after = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        for (int k = 0; k < 8; k++) begin
            check($sformatf("full_pop%0d", k), o_DATA, {8'h00, exp_after[k]});
            pop();
        end
        check("full_drained_valid", 16'(o_VALID), 16'h0);

        // Reset in the middle of data bit 4
        send_byte(8'h33, 1'b1);
        send_byte(8'h55, 1'b0);
        idle(80);
        check("pre_rst_valid", 16'(o_VALID), 16'h1);
        check("pre_rst_ferr", 16'(o_FRAME_ERR), 16'h1);
        send_bit(1'b0);
        i_Serial_RX = 1'b1;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge i_CLK);
        i_RESET = 1'b1;
        repeat (2) @(negedge i_CLK);
        i_RESET = 1'b0;
        @(negedge i_CLK);
        check("mid_rst_valid", 16'(o_VALID), 16'h0);
        check("mid_rst_data", o_DATA, 16'h0000);
        check("mid_rst_ferr", 16'(o_FRAME_ERR), 16'h0);
        check("mid_rst_ovr", 16'(o_OVERRUN), 16'h0);
        idle(6 * BIT_CLKS);
        check("mid_rst_no_partial", 16'(o_VALID), 16'h0);
        send_byte(8'hA5, 1'b1);
        idle(40);
        check("after_rst_valid", 16'(o_VALID), 16'h1);
        check("after_rst_data", o_DATA, 16'h00A5);
        pop();
        check("after_rst_only_one", 16'(o_VALID), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
